// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot decoder / scan sequencer.
package decoder_pkg;

    localparam int unsigned MAX_SEL_W = 8;
    localparam int unsigned MAX_OUTS  = 1 << MAX_SEL_W;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Widest one-hot; callers truncate to their own 2**SEL_W outputs.
    function automatic logic [MAX_OUTS-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Control and decoded-output bundle between a controller and decoder_scan.
interface decoder_scan_if #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 4
);
    logic                    en;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic                    load;
    logic [DWELL_W-1:0]      dwell;
    logic [(1<<SEL_W)-1:0]   y;
    logic [SEL_W-1:0]        idx;
    logic                    wrap;

    modport master (output en, mode, sel, load, dwell, input y, idx, wrap);
    modport slave  (input en, mode, sel, load, dwell, output y, idx, wrap);
endinterface

// File: rtl/decoder_onehot.sv
// Combinational binary-to-one-hot decoder with enable, any select width.
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  en,
    output logic [(1<<SEL_W)-1:0] y_c
);
    localparam int unsigned OUTS = 1 << SEL_W;

    always_comb begin
        y_c = '0;
        if (en) y_c = OUTS'(onehot(MAX_SEL_W'(sel)));
    end
endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with OFF / DIRECT / round-robin SCAN modes.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    decoder_scan_if.slave  bus
);
    localparam int unsigned OUTS = 1 << SEL_W;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 wrap_q, wrap_d;
    logic [OUTS-1:0]      y_q, y_d;
    logic                 dec_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            y_q     <= y_d;
        end
    end

    // Next state, next index/counter and decoder enable.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        dec_en  = 1'b0;

        if (!bus.en)                     state_d = ST_OFF;
        else if (bus.mode == MODE_SCAN)  state_d = ST_SCAN;
        else                             state_d = ST_DIRECT;

        case (state_d)
            ST_DIRECT: begin
                idx_d  = bus.sel;
                cnt_d  = '0;
                dec_en = 1'b1;
            end
            ST_SCAN: begin
                dec_en = 1'b1;
                if (state_q != ST_SCAN || bus.load) begin
                    idx_d = bus.sel;
                    cnt_d = '0;
                end else if (cnt_q >= bus.dwell) begin
                    // >= so a live dwell reduction steps immediately
                    cnt_d  = '0;
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = (idx_q == SEL_W'(OUTS - 1));
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: ;
        endcase
    end

    decoder_onehot #(.SEL_W(SEL_W)) u_onehot (
        .sel (idx_d),
        .en  (dec_en),
        .y_c (y_d)
    );

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan (SEL_W=3, DWELL_W=4).
module tb_decoder_scan;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned DWELL_W = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    decoder_scan_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

    decoder_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] ey, input logic [2:0] ei, input logic ew);
        check({tag, ".y"},    32'(bus.y),    32'(ey));
        check({tag, ".idx"},  32'(bus.idx),  32'(ei));
        check({tag, ".wrap"}, 32'(bus.wrap), 32'(ew));
    endtask

    initial begin
        logic [2:0] ei;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.en = 1'b0; bus.mode = 1'b0; bus.sel = 3'd5; bus.load = 1'b0; bus.dwell = 4'd0;
        #1 rst = 1'b1;
        #1 check_out("rst_async", 8'h00, 3'd0, 1'b0);
        step();
        step();
        #2 rst = 1'b0;

        // OFF after reset, en=0
        for (int k = 0; k < 10; k++) begin
            step();
            check_out("off", 8'h00, 3'd0, 1'b0);
        end

        // DIRECT sweep
        bus.en = 1'b1; bus.mode = 1'b0;
        for (int s = 0; s < 8; s++) begin
            bus.sel = 3'(s);
            step();
            check_out("direct", 8'h01 << s, 3'(s), 1'b0);
        end

        // async reset mid-cycle, then resume on next edge
        #2 rst = 1'b1;
        #1 check_out("rst_mid", 8'h00, 3'd0, 1'b0);
        #1 rst = 1'b0;
        step();
        check_out("post_rst", 8'h80, 3'd7, 1'b0);

        // SCAN dwell=0 from sel=6
        bus.mode = 1'b1; bus.sel = 3'd6; bus.dwell = 4'd0;
        step();
        check_out("scan0_entry", 8'h40, 3'd6, 1'b0);
        bus.sel = 3'd2;
        for (int k = 1; k < 6; k++) begin
            ei = 3'((6 + k) % 8);
            step();
            check_out("scan0", 8'h01 << ei, ei, ei == 3'd0);
        end

        // SCAN dwell=2 from sel=0: each line 3 cycles, wrap every 24
        bus.en = 1'b0;
        step();
        check_out("scan2_off", 8'h00, 3'd3, 1'b0);
        bus.en = 1'b1; bus.sel = 3'd0; bus.dwell = 4'd2;
        for (int t = 0; t < 27; t++) begin
            ei = 3'((t / 3) % 8);
            step();
            check_out("scan2", 8'h01 << ei, ei, (t == 24));
        end

        // load beats a due step; counter restarts
        bus.en = 1'b0;
        step();
        bus.en = 1'b1; bus.sel = 3'd5; bus.dwell = 4'd0;
        step();
        check_out("ld_entry", 8'h20, 3'd5, 1'b0);
        bus.load = 1'b1; bus.sel = 3'd3;
        step();
        check_out("ld_prio", 8'h08, 3'd3, 1'b0);
        bus.load = 1'b0;
        step();
        check_out("ld_after", 8'h10, 3'd4, 1'b0);
        bus.dwell = 4'd2;
        step();
        step();
        bus.load = 1'b1; bus.sel = 3'd1;
        step();
        check_out("ld_restart0", 8'h02, 3'd1, 1'b0);
        bus.load = 1'b0;
        step();
        check_out("ld_restart1", 8'h02, 3'd1, 1'b0);
        step();
        check_out("ld_restart2", 8'h02, 3'd1, 1'b0);
        step();
        check_out("ld_restart3", 8'h04, 3'd2, 1'b0);

        // dwell lowered below the running count
        bus.en = 1'b0;
        step();
        bus.en = 1'b1; bus.sel = 3'd0; bus.dwell = 4'd5;
        for (int k = 0; k < 5; k++) step();
        check_out("dw_hold", 8'h01, 3'd0, 1'b0);
        bus.dwell = 4'd1;
        step();
        check_out("dw_lower", 8'h02, 3'd1, 1'b0);
        step();
        check_out("dw_hold1", 8'h02, 3'd1, 1'b0);
        step();
        check_out("dw_step", 8'h04, 3'd2, 1'b0);

        // en glitch re-enters from sel; then DIRECT
        bus.sel = 3'd4; bus.dwell = 4'd7; bus.en = 1'b0;
        step();
        bus.en = 1'b1;
        step();
        check_out("sw_scan4", 8'h10, 3'd4, 1'b0);
        bus.en = 1'b0;
        step();
        check_out("sw_off", 8'h00, 3'd4, 1'b0);
        bus.en = 1'b1; bus.sel = 3'd1;
        step();
        check_out("sw_reentry", 8'h02, 3'd1, 1'b0);
        bus.mode = 1'b0; bus.sel = 3'd6; bus.load = 1'b1;
        step();
        check_out("sw_direct", 8'h40, 3'd6, 1'b0);
        bus.sel = 3'd7;
        step();
        check_out("sw_direct2", 8'h80, 3'd7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
